// File: rtl/mem_stage.sv
// Memory-access pipeline stage: load/store against an internal word RAM, feeding the MEM/WB register.
// Optional wait-state FSM enabled by defining MEM_WAITSTATE_EN; otherwise every access is single-cycle.
module mem_stage #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] MEMAluRes,
    input  logic [31:0] MEMWriteData,
    input  logic [4:0]  MEMiWriteReg,
    input  logic        MEMiRegWrite,
    input  logic        MEMiMemToReg,
    input  logic        MEMMemRead,
    input  logic        MEMMemWrite,
    input  logic [1:0]  MEMSize,
    input  logic        MEMUnsigned,
    output logic [31:0] WBReadData,
    output logic [31:0] WBAluRes,
    output logic [4:0]  WBiWriteReg,
    output logic        WBiRegWrite,
    output logic        WBMemToReg,
    output logic        MEMStall,
    output logic        MEMMisalign
);

    logic [31:0] ram_q [2**ADDR_W];

    logic              access;
    logic              is_store;
    logic              is_load;
    logic              misalign;
    logic              fault;
    logic              complete;
    logic [1:0]        lane;
    logic [ADDR_W-1:0] widx;

    assign access   = MEMMemRead | MEMMemWrite;
    assign is_store = MEMMemWrite;
    assign is_load  = MEMMemRead & ~MEMMemWrite;
    assign lane     = MEMAluRes[1:0];
    assign widx     = MEMAluRes[ADDR_W+1:2];

    always_comb begin
        misalign = 1'b0;
        case (MEMSize)
            2'b00:   misalign = 1'b0;
            2'b01:   misalign = lane[0];
            default: misalign = (lane != 2'b00);
        endcase
    end

    assign fault = access & misalign;

    logic unused_upper;
    assign unused_upper = ^MEMAluRes[31:ADDR_W+2];

`ifdef MEM_WAITSTATE_EN
    // state | meaning
    // IDLE  | no access in flight; aligned access starts its wait here
    // WAIT  | counting down remaining stall cycles; completes when counter hits 0
    typedef enum logic {IDLE, WAIT} state_t;

    localparam int CW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          start_wait;

    assign start_wait = access & ~misalign & (WAIT_STATES > 0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start_wait) begin
                    state_d = WAIT;
                    cnt_d   = CW'(WAIT_STATES - 1);
                end
            end
            WAIT: begin
                if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
                else             state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        MEMStall = 1'b0;
        complete = 1'b1;
        case (state_q)
            IDLE: begin
                if (start_wait) begin
                    MEMStall = 1'b1;
                    complete = 1'b0;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    MEMStall = 1'b1;
                    complete = 1'b0;
                end
            end
            default: begin
                MEMStall = 1'b0;
                complete = 1'b0;
            end
        endcase
    end
`else
    localparam int unused_wait_states = WAIT_STATES;

    assign MEMStall = 1'b0;
    assign complete = 1'b1;
`endif

    logic [3:0]  be;
    logic [31:0] wlanes;
    logic        we;

    always_comb begin
        be     = 4'b0000;
        wlanes = MEMWriteData;
        case (MEMSize)
            2'b00: begin
                be     = 4'b0001 << lane;
                wlanes = {4{MEMWriteData[7:0]}};
            end
            2'b01: begin
                be     = lane[1] ? 4'b1100 : 4'b0011;
                wlanes = {2{MEMWriteData[15:0]}};
            end
            default: begin
                be     = 4'b1111;
                wlanes = MEMWriteData;
            end
        endcase
    end

    // Gating with rst_n keeps a reset that overlaps the completing edge from committing the store.
    assign we = complete & is_store & ~misalign & rst_n;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) ram_q[widx][8*b +: 8] <= wlanes[8*b +: 8];
            end
        end
    end

    logic [31:0] rword;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    logic [31:0] load_data;

    assign rword = ram_q[widx];
    assign rhalf = lane[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        rbyte = rword[7:0];
        case (lane)
            2'b00: rbyte = rword[7:0];
            2'b01: rbyte = rword[15:8];
            2'b10: rbyte = rword[23:16];
            2'b11: rbyte = rword[31:24];
            default: rbyte = rword[7:0];
        endcase
    end

    always_comb begin
        load_data = 32'h0;
        if (is_load && !misalign) begin
            case (MEMSize)
                2'b00:   load_data = MEMUnsigned ? {24'h0, rbyte} : {{24{rbyte[7]}}, rbyte};
                2'b01:   load_data = MEMUnsigned ? {16'h0, rhalf} : {{16{rhalf[15]}}, rhalf};
                default: load_data = rword;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            WBReadData  <= 32'h0;
            WBAluRes    <= 32'h0;
            WBiWriteReg <= 5'h0;
            WBiRegWrite <= 1'b0;
            WBMemToReg  <= 1'b0;
            MEMMisalign <= 1'b0;
        end else if (!complete) begin
            WBReadData  <= 32'h0;
            WBAluRes    <= 32'h0;
            WBiWriteReg <= 5'h0;
            WBiRegWrite <= 1'b0;
            WBMemToReg  <= 1'b0;
            MEMMisalign <= 1'b0;
        end else begin
            WBReadData  <= load_data;
            WBAluRes    <= MEMAluRes;
            WBiWriteReg <= MEMiWriteReg;
            WBiRegWrite <= MEMiRegWrite & ~fault;
            WBMemToReg  <= MEMiMemToReg;
            MEMMisalign <= fault;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized loads/stores against a word-array model.
module tb_mem_stage;

`ifdef MEM_WAITSTATE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] MEMAluRes = '0;
    logic [31:0] MEMWriteData = '0;
    logic [4:0]  MEMiWriteReg = '0;
    logic        MEMiRegWrite = 1'b0;
    logic        MEMiMemToReg = 1'b0;
    logic        MEMMemRead = 1'b0;
    logic        MEMMemWrite = 1'b0;
    logic [1:0]  MEMSize = '0;
    logic        MEMUnsigned = 1'b0;
    logic [31:0] WBReadData;
    logic [31:0] WBAluRes;
    logic [4:0]  WBiWriteReg;
    logic        WBiRegWrite;
    logic        WBMemToReg;
    logic        MEMStall;
    logic        MEMMisalign;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mdl [256];

    mem_stage #(.ADDR_W(8), .WAIT_STATES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .MEMAluRes(MEMAluRes), .MEMWriteData(MEMWriteData),
        .MEMiWriteReg(MEMiWriteReg), .MEMiRegWrite(MEMiRegWrite),
        .MEMiMemToReg(MEMiMemToReg), .MEMMemRead(MEMMemRead),
        .MEMMemWrite(MEMMemWrite), .MEMSize(MEMSize), .MEMUnsigned(MEMUnsigned),
        .WBReadData(WBReadData), .WBAluRes(WBAluRes), .WBiWriteReg(WBiWriteReg),
        .WBiRegWrite(WBiRegWrite), .WBMemToReg(WBMemToReg),
        .MEMStall(MEMStall), .MEMMisalign(MEMMisalign)
    );

    always #5 clk = ~clk;

    function automatic bit ref_fault(input logic [31:0] a, input logic [1:0] sz);
        if (sz == 2'd0) return 1'b0;
        if (sz == 2'd1) return a[0];
        return a[1:0] != 2'd0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic uns);
        logic [31:0] w;
        int sh;
        sh = 8 * int'(a[1:0]);
        w  = mdl[a[9:2]] >> sh;
        if (sz == 2'd0) begin
            w = w & 32'hFF;
            if (!uns && w >= 32'h80) w = w | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            w = w & 32'hFFFF;
            if (!uns && w >= 32'h8000) w = w | 32'hFFFF_0000;
        end
        return w;
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        logic [31:0] mask;
        int sh;
        sh   = 8 * int'(a[1:0]);
        mask = (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
        mask = mask << sh;
        mdl[a[9:2]] = (mdl[a[9:2]] & ~mask) | ((d << sh) & mask);
    endtask

    task automatic set_idle();
        MEMAluRes = '0; MEMWriteData = '0; MEMiWriteReg = '0; MEMiRegWrite = 1'b0;
        MEMiMemToReg = 1'b0; MEMMemRead = 1'b0; MEMMemWrite = 1'b0;
        MEMSize = '0; MEMUnsigned = 1'b0;
    endtask

    // Presents one instruction and advances until its completing edge; outputs are then valid.
    task automatic do_access(input logic [31:0] a, input logic [31:0] d, input logic rd, input logic wr,
                             input logic [1:0] sz, input logic uns, input logic [4:0] wreg,
                             input logic regwr, input logic m2r,
                             output int stalls, output bit bubble_bad, output bit timeout);
        logic s;
        MEMAluRes = a; MEMWriteData = d; MEMMemRead = rd; MEMMemWrite = wr; MEMSize = sz;
        MEMUnsigned = uns; MEMiWriteReg = wreg; MEMiRegWrite = regwr; MEMiMemToReg = m2r;
        stalls = 0; bubble_bad = 1'b0; timeout = 1'b1;
        for (int c = 0; c < 20; c++) begin
            s = MEMStall;
            @(posedge clk); #1;
            if (!s) begin
                timeout = 1'b0;
                break;
            end
            stalls++;
            if (WBiRegWrite !== 1'b0 || MEMMisalign !== 1'b0 || WBAluRes !== 32'h0) bubble_bad = 1'b1;
        end
    endtask

    task automatic test_reset();
        #3;
        n_tests++;
        if ({WBReadData, WBAluRes, WBiWriteReg, WBiRegWrite, WBMemToReg, MEMMisalign, MEMStall} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rd=%h alu=%h wr=%h rw=%b m2r=%b mis=%b stall=%b, want all 0",
                     WBReadData, WBAluRes, WBiWriteReg, WBiRegWrite, WBMemToReg, MEMMisalign, MEMStall);
        end
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_alu();
        int st; bit bb, to;
        bit stall_seen;
        stall_seen = MEMStall;
        do_access(32'hCAFE_0001, 32'h0, 1'b0, 1'b0, 2'd2, 1'b0, 5'd5, 1'b1, 1'b0, st, bb, to);
        n_tests++;
        if (st != 0 || stall_seen) begin n_fail++; $display("FAIL alu_stall: got %0d stalls, want 0", st); end
        n_tests++;
        if ({WBAluRes, WBiWriteReg, WBiRegWrite, WBReadData} !== {32'hCAFE_0001, 5'd5, 1'b1, 32'h0}) begin
            n_fail++;
            $display("FAIL alu_capture: got alu=%h wreg=%0d rw=%b rd=%h, want cafe0001 5 1 0",
                     WBAluRes, WBiWriteReg, WBiRegWrite, WBReadData);
        end
        set_idle();
    endtask

    task automatic test_word_store_load();
        int st; bit bb, to;
        do_access(32'h20, 32'h1234_5678, 1'b0, 1'b1, 2'd2, 1'b0, 5'd0, 1'b0, 1'b0, st, bb, to);
        n_tests++;
        if (st != LAT || bb || to) begin
            n_fail++; $display("FAIL word_store_stall: got %0d stalls bubble_bad=%b, want %0d clean", st, bb, LAT);
        end
        n_tests++;
        if (WBiRegWrite !== 1'b0) begin n_fail++; $display("FAIL word_store_rw: got %b, want 0", WBiRegWrite); end
        do_access(32'h20, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 5'd7, 1'b1, 1'b1, st, bb, to);
        n_tests++;
        if (st != LAT || WBReadData !== 32'h1234_5678) begin
            n_fail++; $display("FAIL word_load: got %h after %0d stalls, want 12345678 after %0d", WBReadData, st, LAT);
        end
        n_tests++;
        if ({WBiRegWrite, WBMemToReg, WBiWriteReg} !== {1'b1, 1'b1, 5'd7}) begin
            n_fail++; $display("FAIL word_load_ctrl: got rw=%b m2r=%b wreg=%0d, want 1 1 7", WBiRegWrite, WBMemToReg, WBiWriteReg);
        end
        ref_store(32'h20, 32'h1234_5678, 2'd2);
        set_idle();
    endtask

    task automatic test_byte_ext();
        int st; bit bb, to;
        logic [31:0] want [3];
        logic [31:0] adr [3];
        logic        un [3];
        want = '{32'h0000_007F, 32'hFFFF_FF80, 32'h0000_0080};
        adr  = '{32'h24, 32'h25, 32'h25};
        un   = '{1'b0, 1'b0, 1'b1};
        do_access(32'h24, 32'h0000_807F, 1'b0, 1'b1, 2'd2, 1'b0, 5'd0, 1'b0, 1'b0, st, bb, to);
        ref_store(32'h24, 32'h0000_807F, 2'd2);
        for (int i = 0; i < 3; i++) begin
            do_access(adr[i], 32'h0, 1'b1, 1'b0, 2'd0, un[i], 5'd3, 1'b1, 1'b1, st, bb, to);
            n_tests++;
            if (WBReadData !== want[i]) begin
                n_fail++; $display("FAIL byte_ext_%0d: got %h, want %h", i, WBReadData, want[i]);
            end
        end
        set_idle();
    endtask

    task automatic test_half_lane();
        int st; bit bb, to;
        do_access(32'h28, 32'h1122_3344, 1'b0, 1'b1, 2'd2, 1'b0, 5'd0, 1'b0, 1'b0, st, bb, to);
        do_access(32'h2A, 32'hAAAA_BEEF, 1'b0, 1'b1, 2'd1, 1'b0, 5'd0, 1'b0, 1'b0, st, bb, to);
        do_access(32'h28, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 5'd4, 1'b1, 1'b1, st, bb, to);
        n_tests++;
        if (WBReadData !== 32'hBEEF_3344) begin
            n_fail++; $display("FAIL half_lane: got %h, want beef3344", WBReadData);
        end
        ref_store(32'h28, 32'hBEEF_3344, 2'd2);
        set_idle();
    endtask

    task automatic test_misalign();
        int st; bit bb, to;
        do_access(32'h30, 32'hA5A5_A5A5, 1'b0, 1'b1, 2'd2, 1'b0, 5'd0, 1'b0, 1'b0, st, bb, to);
        do_access(32'h31, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 5'd9, 1'b1, 1'b1, st, bb, to);
        n_tests++;
        if (st != 0 || {MEMMisalign, WBiRegWrite, WBReadData} !== {1'b1, 1'b0, 32'h0}) begin
            n_fail++; $display("FAIL misalign_load: got stalls=%0d mis=%b rw=%b rd=%h, want 0 1 0 0",
                               st, MEMMisalign, WBiRegWrite, WBReadData);
        end
        set_idle();
        @(posedge clk); #1;
        n_tests++;
        if (MEMMisalign !== 1'b0) begin n_fail++; $display("FAIL misalign_pulse: got %b, want 0", MEMMisalign); end
        do_access(32'h32, 32'hFFFF_FFFF, 1'b0, 1'b1, 2'd2, 1'b0, 5'd0, 1'b0, 1'b0, st, bb, to);
        do_access(32'h33, 32'hFFFF_FFFF, 1'b0, 1'b1, 2'd1, 1'b0, 5'd0, 1'b0, 1'b0, st, bb, to);
        do_access(32'h30, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 5'd9, 1'b1, 1'b1, st, bb, to);
        n_tests++;
        if (WBReadData !== 32'hA5A5_A5A5) begin
            n_fail++; $display("FAIL misalign_ram_unchanged: got %h, want a5a5a5a5", WBReadData);
        end
        ref_store(32'h30, 32'hA5A5_A5A5, 2'd2);
        set_idle();
    endtask

    task automatic test_store_wins();
        int st; bit bb, to;
        do_access(32'h34, 32'h0000_0055, 1'b1, 1'b1, 2'd2, 1'b0, 5'd2, 1'b0, 1'b0, st, bb, to);
        n_tests++;
        if (WBReadData !== 32'h0) begin n_fail++; $display("FAIL store_wins_rd: got %h, want 0", WBReadData); end
        do_access(32'h34, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 5'd2, 1'b1, 1'b1, st, bb, to);
        n_tests++;
        if (WBReadData !== 32'h55) begin n_fail++; $display("FAIL store_wins_ram: got %h, want 00000055", WBReadData); end
        ref_store(32'h34, 32'h55, 2'd2);
        set_idle();
    endtask

    task automatic test_reset_mid();
        int st; bit bb, to;
        do_access(32'h10, 32'h0, 1'b0, 1'b1, 2'd2, 1'b0, 5'd0, 1'b0, 1'b0, st, bb, to);
        MEMAluRes = 32'h10; MEMWriteData = 32'hDEAD_BEEF; MEMMemWrite = 1'b1; MEMSize = 2'd2;
        if (LAT > 0) begin
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({WBReadData, WBAluRes, WBiWriteReg, WBiRegWrite, WBMemToReg, MEMMisalign} !== '0) begin
            n_fail++; $display("FAIL reset_mid_outputs: got rd=%h alu=%h rw=%b, want all 0", WBReadData, WBAluRes, WBiRegWrite);
        end
        repeat (2) @(posedge clk);
        #1 set_idle();
        #2 rst_n = 1'b1;
        #1;
        n_tests++;
        if (MEMStall !== 1'b0) begin n_fail++; $display("FAIL reset_mid_idle: got stall %b, want 0", MEMStall); end
        do_access(32'h10, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 5'd1, 1'b1, 1'b1, st, bb, to);
        n_tests++;
        if (WBReadData !== 32'h0 || st != LAT) begin
            n_fail++; $display("FAIL reset_mid_nowrite: got %h after %0d stalls, want 00000000 after %0d", WBReadData, st, LAT);
        end
        ref_store(32'h10, 32'h0, 2'd2);
        set_idle();
    endtask

    task automatic test_random();
        int st; bit bb, to;
        logic [31:0] a, d, exp_rd;
        logic [1:0]  sz;
        logic        rd, wr, uns, flt;
        logic [4:0]  wreg;
        int          errs;
        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            do_access(32'h100 + 32'(4 * i), d, 1'b0, 1'b1, 2'd2, 1'b0, 5'd0, 1'b0, 1'b0, st, bb, to);
            ref_store(32'h100 + 32'(4 * i), d, 2'd2);
        end
        for (int i = 0; i < 80; i++) begin
            a    = ($urandom & 32'hFFFF_FC00) | (32'h100 + 32'($urandom_range(0, 63)));
            d    = $urandom;
            sz   = 2'($urandom_range(0, 3));
            uns  = 1'($urandom_range(0, 1));
            wreg = 5'($urandom_range(1, 31));
            case ($urandom_range(0, 3))
                0:       begin rd = 1'b1; wr = 1'b1; end
                1:       begin rd = 1'b0; wr = 1'b1; end
                default: begin rd = 1'b1; wr = 1'b0; end
            endcase
            flt    = ref_fault(a, sz);
            exp_rd = (wr || flt) ? 32'h0 : ref_load(a, sz, uns);
            do_access(a, d, rd, wr, sz, uns, wreg, rd, rd, st, bb, to);
            if (wr && !flt) ref_store(a, d, sz);
            errs = 0;
            n_tests++;
            if (st != (flt ? 0 : LAT) || bb || to) begin
                n_fail++; errs++;
                $display("FAIL rand_%0d_stall: got %0d stalls bb=%b to=%b, want %0d", i, st, bb, to, flt ? 0 : LAT);
            end
            n_tests++;
            if (WBReadData !== exp_rd || WBAluRes !== a) begin
                n_fail++; errs++;
                $display("FAIL rand_%0d_data: addr=%h sz=%0d u=%b rd=%b wr=%b got rd=%h alu=%h, want rd=%h alu=%h",
                         i, a, sz, uns, rd, wr, WBReadData, WBAluRes, exp_rd, a);
            end
            n_tests++;
            if ({WBiRegWrite, MEMMisalign, WBiWriteReg} !== {rd & ~flt, flt, wreg}) begin
                n_fail++; errs++;
                $display("FAIL rand_%0d_ctrl: got rw=%b mis=%b wreg=%0d, want %b %b %0d",
                         i, WBiRegWrite, MEMMisalign, WBiWriteReg, rd & ~flt, flt, wreg);
            end
            if (errs > 0) break;
        end
        set_idle();
    endtask

    initial begin
        set_idle();
        test_reset();
        test_alu();
        test_word_store_load();
        test_byte_ext();
        test_half_lane();
        test_misalign();
        test_store_wins();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage directly upstream of the write-back stage.
- Takes EX/MEM pipeline values and performs load/store against an internal data RAM, with byte, halfword and word access and sign/zero extension.
- Registers the results into the MEM/WB pipeline register that feeds write-back.
- Supports a configurable wait-state latency and stalls upstream while an access is in progress.

Parameters:
- ADDR_W, 8, word-address width; RAM depth = 2^ADDR_W 32-bit words.
- WAIT_STATES, 2, extra stall cycles per load/store (0 = single-cycle access).

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- MEMAluRes  input  32  ALU result; byte address for loads/stores.
- MEMWriteData  input  32  store data, taken from the low-order lanes.
- MEMiWriteReg  input  5  destination register number.
- MEMiRegWrite  input  1  register write enable.
- MEMiMemToReg  input  1  write-back source select.
- MEMMemRead  input  1  load request.
- MEMMemWrite  input  1  store request.
- MEMSize  input  2  00 byte, 01 half, 10 word, 11 treated as word.
- MEMUnsigned  input  1  zero-extend loads when 1, sign-extend when 0.
- WBReadData  output  32  registered, extended load data.
- WBAluRes  output  32  registered MEMAluRes.
- WBiWriteReg  output  5  registered destination register.
- WBiRegWrite  output  1  registered write enable; forced 0 for bubbles and faults.
- WBMemToReg  output  1  registered MEMiMemToReg.
- MEMStall  output  1  combinational; upstream holds EX/MEM inputs while high.
- MEMMisalign  output  1  registered one-cycle fault pulse.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All registered outputs go to 0; FSM goes to IDLE; wait counter goes to 0.
  - RAM contents are not reset.
  - Reset asserted during WAIT aborts the access; no RAM write occurs.
- Access definition: access = MEMMemRead | MEMMemWrite. If both are set, the store wins and WBReadData = 0.
- Addressing:
  - Word index = MEMAluRes[ADDR_W+1:2]; upper address bits are ignored, so addresses wrap modulo the RAM size.
  - Lane = MEMAluRes[1:0], little-endian (lane 0 = bits 7:0).
- Misalignment:
  - Faults are: half access with addr[0]=1, and word access with addr[1:0]≠0.
  - A misaligned access completes immediately, with no wait states and no stall.
  - On completion: no RAM write, WBiRegWrite = 0, WBReadData = 0, MEMMisalign = 1 for one cycle.
- FSM states: IDLE, WAIT.
  - IDLE, no access: MEMStall = 0. MEM/WB captures the inputs on the next edge, and WBReadData = 0.
  - IDLE, aligned access, WAIT_STATES > 0: MEMStall = 1 that cycle. Counter loads WAIT_STATES−1 and the FSM goes to WAIT. MEM/WB loads a bubble (all 0).
  - WAIT, counter ≠ 0: MEMStall = 1, counter decrements, MEM/WB loads a bubble.
  - WAIT, counter = 0: MEMStall = 0. The access completes on this edge and the FSM returns to IDLE.
  - Net effect: MEMStall is high for exactly WAIT_STATES cycles, and the result reaches the outputs WAIT_STATES+1 edges after the access is first presented.
  - Upstream inputs must be held stable while MEMStall is high; changes during WAIT are undefined.
- Completion (aligned access, or any cycle with WAIT_STATES = 0):
  - Store: RAM byte-enables are set per MEMSize/lane and the store data is written at the completing edge. Byte stores use MEMWriteData[7:0], half stores use [15:0], word stores the full value.
  - Load: the addressed word is read, the lane is extracted and extended per MEMUnsigned, and the result is registered into WBReadData.
  - WBAluRes, WBiWriteReg, WBiRegWrite and WBMemToReg capture their inputs on the same edge.
- Back-to-back accesses: each access independently incurs WAIT_STATES stall cycles.
- Load after store: a load completing after a store to the same word returns the stored data, since the store has already been committed.

Optional Feature:
- Macro: MEM_WAITSTATE_EN.
- Defined: wait-state FSM as described above.
- Undefined: WAIT_STATES is ignored, the FSM and counter are omitted, MEMStall is tied to 0, and every access completes on the edge after presentation.

Test Plan:
- Reset mid-access: assert rst_n low in WAIT during a store of 0xDEADBEEF to address 0x10 → all outputs 0, FSM in IDLE; a subsequent load from 0x10 does not return 0xDEADBEEF (RAM pre-written with 0 beforehand).
- Word store then load, WAIT_STATES = 2:
  - Store 0x12345678 to address 0x20 → MEMStall high for 2 cycles, then WBiRegWrite = 0 bubbles.
  - Load from 0x20 → WBReadData = 0x12345678 three edges after the request.
- Byte load sign/zero extension: with word 0x0000807F at 0x24, load byte at 0x24 signed → 0x0000007F; byte at 0x25 signed → 0xFFFFFF80; byte at 0x25 unsigned → 0x00000080.
- Half store lane: store half 0xBEEF to 0x2A over word 0x11223344 at 0x28 → word load returns 0xBEEF3344.
- Misaligned word load at 0x31 → no stall, MEMMisalign = 1 for one cycle, WBiRegWrite = 0, RAM unchanged.
- Non-memory ALU instruction: MEMAluRes = 0xCAFE0001, WriteReg = 5, RegWrite = 1 → after one edge WBAluRes = 0xCAFE0001, WBiWriteReg = 5, WBiRegWrite = 1, MEMStall = 0 throughout.
